// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480@60 defaults) used by the sync generator,
// the pixel source and the top level.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // Sync pulses are active-low for the 640x480 mode.
  localparam logic HS_POL_DEF = 1'b0;
  localparam logic VS_POL_DEF = 1'b0;

  localparam int CW_DEF = 10;

endpackage

// File: rtl/vga_axis_cnt.sv
// Wrap counter for one raster axis: counts 0..LAST on inc, resets to LAST.
// Exposes the next-state value so the parent can decode registered outputs.
module vga_axis_cnt #(
  parameter int             CW   = 10,
  parameter logic [CW-1:0]  LAST = '1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic [CW-1:0] count_nxt,
  output logic          tc
);

  assign tc = (count == LAST);

  // Wrap is an explicit compare against LAST, not natural overflow.
  always_comb begin
    count_nxt = count;
    if (inc) begin
      count_nxt = tc ? '0 : count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= LAST;
    end else begin
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing generator: advances h/v position on each pixel strobe and
// produces registered sync, active-video and line/frame start outputs.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_DEF,
  parameter int   H_FP     = H_FP_DEF,
  parameter int   H_SYNC   = H_SYNC_DEF,
  parameter int   H_BP     = H_BP_DEF,
  parameter int   V_ACTIVE = V_ACTIVE_DEF,
  parameter int   V_FP     = V_FP_DEF,
  parameter int   V_SYNC   = V_SYNC_DEF,
  parameter int   V_BP     = V_BP_DEF,
  parameter logic HS_POL   = HS_POL_DEF,
  parameter logic VS_POL   = VS_POL_DEF,
  parameter int   CW       = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [CW-1:0] h_nxt;
  logic [CW-1:0] v_nxt;
  logic          h_tc;
  logic          v_tc;

  vga_axis_cnt #(.CW(CW), .LAST(H_LAST)) u_h_cnt (
    .clk       (clk),
    .rst       (rst),
    .inc       (en),
    .count     (x),
    .count_nxt (h_nxt),
    .tc        (h_tc)
  );

  vga_axis_cnt #(.CW(CW), .LAST(V_LAST)) u_v_cnt (
    .clk       (clk),
    .rst       (rst),
    .inc       (en & h_tc),
    .count     (y),
    .count_nxt (v_nxt),
    .tc        (v_tc)
  );

  // Decode from next-state counts so outputs line up with the x/y they accompany.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      video_on    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (en) begin
        video_on    <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
        hsync       <= ((h_nxt >= HS_BEG) && (h_nxt <= HS_END)) ? HS_POL : ~HS_POL;
        vsync       <= ((v_nxt >= VS_BEG) && (v_nxt <= VS_END)) ? VS_POL : ~VS_POL;
        line_start  <= h_tc;
        frame_start <= h_tc & v_tc;
      end
    end
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Raster timing generator for the VGA output path. It consumes the single-cycle pixel-enable strobe from the pixel clock divider and advances horizontal and vertical position counters. It produces the hsync/vsync pulses, the active-video flag, the current pixel coordinates and line/frame start strobes for the pixel source downstream. Everything runs in the 100 MHz system clock domain; the pixel rate is set entirely by the enable strobe.

## Interface

Parameters:
- H_ACTIVE, 640: visible pixels per line
- H_FP, 16: horizontal front porch, pixels
- H_SYNC, 96: hsync pulse width, pixels
- H_BP, 48: horizontal back porch, pixels
- V_ACTIVE, 480: visible lines per frame
- V_FP, 10: vertical front porch, lines
- V_SYNC, 2: vsync pulse width, lines
- V_BP, 33: vertical back porch, lines
- HS_POL, 0: hsync active level
- VS_POL, 0: vsync active level
- CW, 10: counter / coordinate width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk, input, 1: system clock, 100 MHz
- rst, input, 1: reset, synchronous, active-low (0 = reset)
- en, input, 1: pixel strobe, one pixel per clk cycle with en=1
- hsync, output, 1: horizontal sync
- vsync, output, 1: vertical sync
- video_on, output, 1: current position is inside the active area
- x, output, CW: current horizontal position (hcount)
- y, output, CW: current vertical position (vcount)
- line_start, output, 1: one-clk pulse when x becomes 0
- frame_start, output, 1: one-clk pulse when (x,y) becomes (0,0)

## Operation

- Definitions:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800).
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Reset (rst=0 at a clk edge):
  - hcount = H_TOTAL-1 (799), vcount = V_TOTAL-1 (524).
  - hsync = ~HS_POL, vsync = ~VS_POL.
  - video_on = 0, line_start = 0, frame_start = 0.
  - Reset parks the raster on the last pixel of the frame, so the first strobe after reset starts a clean frame.
- Reset has priority over en. A reset mid-frame abandons the frame immediately.
- On a clk edge with rst=1, en=1:
  - hcount wraps H_TOTAL-1 → 0, otherwise increments.
  - vcount increments only when hcount wraps. vcount wraps V_TOTAL-1 → 0.
- With en=0, all counters and level outputs hold. line_start and frame_start are forced to 0.
- All outputs are registered and decoded from the next-state counter values, so every output is consistent with the x/y value visible in the same cycle:
  - video_on = (hcount < H_ACTIVE) && (vcount < V_ACTIVE).
  - hsync = HS_POL when H_ACTIVE+H_FP ≤ hcount ≤ H_ACTIVE+H_FP+H_SYNC-1 (656..751), else ~HS_POL.
  - vsync = VS_POL when V_ACTIVE+V_FP ≤ vcount ≤ V_ACTIVE+V_FP+V_SYNC-1 (490..491), else ~VS_POL. vsync changes only on the same edge as an hcount wrap.
  - line_start = 1 for the one clk following an edge where hcount wrapped to 0.
  - frame_start = 1 for the one clk following an edge where both counters wrapped to 0. It coincides with line_start.
- Arithmetic is unsigned, CW bits. The wrap is a compare against the TOTAL-1 constant, not natural overflow.

## Timing

- Latency: an en=1 sampled at edge k makes the new position and all decoded outputs visible immediately after edge k (0 extra pipeline stages).
- en may be asserted every cycle (continuous). In that case the raster advances one pixel per clk.
- en pulses may be irregularly spaced. Line and frame length are measured in strobes, not clks.
- hsync low width = H_SYNC strobes; vsync low width = V_SYNC × H_TOTAL strobes.
- After rst returns to 1, outputs hold their reset values until the first en.

## Structure

- Shared package vga_pkg holds:
  - the 640x480@60 default timing constants
  - derived H_TOTAL/V_TOTAL
  - the sync polarity constants
- These are shared with the pixel source and the top-level.
- A natural sub-module is vga_axis_cnt: a wrap counter with inc enable, a terminal-count flag and a synchronous active-low reset value. It is instantiated once for horizontal and once for vertical, with the vertical inc driven by the horizontal terminal-count AND en.
- Sync/active decode and strobe registers live in vga_sync_gen.

## Test plan

- Hold rst=0 for 3 clk with en toggling → x=799, y=524, hsync=vsync=1, video_on=0, line_start=frame_start=0 throughout.
- Release rst, first en=1 → next cycle x=0, y=0, video_on=1, line_start=frame_start=1 for exactly one clk. Both are 0 on the following clk even if en stays low.
- en every 4th clk → hsync low exactly 384 clk, starting the cycle x becomes 656. Line period is 3200 clk. video_on falls when x becomes 640.
- en tied high → vsync low while y=490..491, i.e. exactly 1600 clk. frame_start pulses are 420000 clk apart. video_on is high for 307200 clk per frame.
- rst=0 at x=300, y=200 with en=1 on the same edge → next cycle x=799, y=524, reset values on all outputs. The next en gives (0,0) with frame_start=1.
- Sweep to y=524, x=799 with en=1 → wrap to (0,0), vsync stays inactive, frame_start=1. y never reads 525 and x never reads 800.
